lfsr_byte_streamer: RTL

Downstream consumer and controller of an `LFSR` generator instance. It drives the generator's `E`, `RESET` and `SEED_VAL` inputs and captures each `NUM_BITS`-wide pseudo-random word. It then streams that word as bytes over a valid/ready handshake to the MCS-51 peripheral read port. It also supports runtime reseeding and counts completed words.

---
 rtl/lfsr_stream_pkg.sv | 17 +
 rtl/byte_shifter.sv | 39 +++
 rtl/lfsr_byte_streamer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lfsr_stream_pkg.sv
// Shared types and constants for the LFSR byte streamer.
package lfsr_stream_pkg;

  typedef enum logic [1:0] {
    S_SEED = 2'd0,
    S_STEP = 2'd1,
    S_LOAD = 2'd2,
    S_SEND = 2'd3
  } state_t;

  localparam logic [63:0] DEFAULT_SEED = 64'h0000_0000_0000_0001;

  function automatic int num_bytes(input int num_bits);
    return num_bits / 32'sd8;
  endfunction

endpackage

// File: rtl/byte_shifter.sv
// Loadable right-shift register that walks a captured word out one byte at a time.
module byte_shifter
  import lfsr_stream_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                load,
  input  logic                shift,
  input  logic [NUM_BITS-1:0] din,
  output logic [7:0]          byte_out,
  output logic                last
);

  localparam int NB    = num_bytes(NUM_BITS);
  localparam int IDX_W = $clog2(NB + 1);

  logic [NUM_BITS-1:0] sh_r;
  logic [IDX_W-1:0]    idx_r;

  // Word capture has priority over shifting; index tracks the byte on display.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sh_r  <= {NUM_BITS{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (load) begin
      sh_r  <= din;
      idx_r <= {IDX_W{1'b0}};
    end else if (shift) begin
      sh_r  <= sh_r >> 4'd8;
      idx_r <= idx_r + IDX_W'(1);
    end
  end

  assign byte_out = sh_r[7:0];
  assign last     = (idx_r == IDX_W'(NB - 1));

endmodule

// File: rtl/lfsr_byte_streamer.sv
// Drives an external LFSR generator, captures each word and streams it LSB byte
// first over valid/ready, with runtime reseeding and a completed-word counter.
module lfsr_byte_streamer
  import lfsr_stream_pkg::*;
#(
  parameter int                  NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0] SEED     = NUM_BITS'(DEFAULT_SEED)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SEED_LD,
  input  logic [NUM_BITS-1:0] SEED_IN,
  output logic                LFSR_E,
  output logic                LFSR_RESET,
  output logic [NUM_BITS-1:0] LFSR_SEED,
  input  logic [NUM_BITS-1:0] LFSR_VAL,
  output logic [7:0]          BYTE_OUT,
  output logic                BYTE_VALID,
  input  logic                BYTE_READY,
  output logic [15:0]         WORD_CNT,
  output logic                BUSY
);

  state_t              state_r;
  logic [NUM_BITS-1:0] seed_r;
  logic                lfsr_e_r;
  logic                lfsr_reset_r;
  logic                byte_valid_r;
  logic                busy_r;
  logic [15:0]         word_cnt_r;

  logic                hs_s;
  logic                load_s;
  logic                last_s;
  logic [NUM_BITS-1:0] seed_guard_s;

  // Handshake decode and lock-up guard (all-ones would freeze an XNOR LFSR).
  always_comb begin
    hs_s   = byte_valid_r & BYTE_READY;
    load_s = (state_r == S_LOAD);
    if (SEED_IN == {NUM_BITS{1'b1}}) begin
      seed_guard_s = SEED;
    end else begin
      seed_guard_s = SEED_IN;
    end
  end

  byte_shifter #(
    .NUM_BITS (NUM_BITS)
  ) u_shifter (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (load_s),
    .shift    (hs_s),
    .din      (LFSR_VAL),
    .byte_out (BYTE_OUT),
    .last     (last_s)
  );

  // Sequencer; S_SEED holds until its load pulse has actually been presented.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= S_SEED;
      seed_r       <= SEED;
      lfsr_e_r     <= 1'b0;
      lfsr_reset_r <= 1'b0;
      byte_valid_r <= 1'b0;
      busy_r       <= 1'b1;
      word_cnt_r   <= 16'h0000;
    end else begin
      lfsr_e_r     <= 1'b0;
      lfsr_reset_r <= 1'b0;
      if (SEED_LD) begin
        seed_r       <= seed_guard_s;
        word_cnt_r   <= 16'h0000;
        state_r      <= S_SEED;
        lfsr_e_r     <= 1'b1;
        lfsr_reset_r <= 1'b1;
        byte_valid_r <= 1'b0;
        busy_r       <= 1'b1;
      end else begin
        case (state_r)
          S_SEED: begin
            if (lfsr_reset_r) begin
              state_r <= S_LOAD;
            end else begin
              lfsr_e_r     <= 1'b1;
              lfsr_reset_r <= 1'b1;
            end
          end
          S_STEP: begin
            state_r <= S_LOAD;
          end
          S_LOAD: begin
            state_r      <= S_SEND;
            byte_valid_r <= 1'b1;
            busy_r       <= 1'b0;
          end
          S_SEND: begin
            if (hs_s && last_s) begin
              word_cnt_r   <= word_cnt_r + 16'd1;
              state_r      <= S_STEP;
              lfsr_e_r     <= 1'b1;
              byte_valid_r <= 1'b0;
              busy_r       <= 1'b1;
            end
          end
          default: begin
            state_r      <= S_SEED;
            byte_valid_r <= 1'b0;
            busy_r       <= 1'b1;
          end
        endcase
      end
    end
  end

  assign LFSR_E     = lfsr_e_r;
  assign LFSR_RESET = lfsr_reset_r;
  assign LFSR_SEED  = seed_r;
  assign BYTE_VALID = byte_valid_r;
  assign BUSY       = busy_r;
  assign WORD_CNT   = word_cnt_r;

endmodule
